// File: rtl/lut_programavel_if.sv
// Bundles the evaluate, program and clear ports of lut_programavel.
// master drives requests (datapath side), slave is the function unit.
interface lut_programavel_if #(
  parameter int N_SEL = 3,
  parameter int N_DEC = 4
);
  logic [N_SEL+N_DEC-1:0] entrada;
  logic                   entrada_valid;
  logic                   entrada_ready;
  logic                   saida;
  logic                   saida_valid;
  logic [N_SEL-1:0]       prog_ender;
  logic [(1<<N_DEC)-1:0]  prog_mascara;
  logic                   prog_valid;
  logic                   prog_ready;
  logic                   limpar;
  logic                   ocupado;

  modport master (
    output entrada, entrada_valid, prog_ender, prog_mascara, prog_valid, limpar,
    input  entrada_ready, saida, saida_valid, prog_ready, ocupado
  );

  modport slave (
    input  entrada, entrada_valid, prog_ender, prog_mascara, prog_valid, limpar,
    output entrada_ready, saida, saida_valid, prog_ready, ocupado
  );
endinterface

// File: rtl/lut_programavel.sv
// Programmable Boolean function: row-mask table indexed by the upper input bits,
// bit picked by a one-hot decode of the lower bits, 2-stage pipeline, sequenced clear.
// Optional LUT_PROGRAMAVEL_PADRAO_EN: reset loads the default table instead of zeros.
module lut_programavel #(
  parameter int N_SEL = 3,
  parameter int N_DEC = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  lut_programavel_if.slave bus
);

  localparam int ROWS   = 1 << N_SEL;
  localparam int MASK_W = 1 << N_DEC;

`ifdef LUT_PROGRAMAVEL_PADRAO_EN
  localparam bit PADRAO_EN = 1'b1;
`else
  localparam bit PADRAO_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

  estado_t             estado_r;
  logic [N_SEL-1:0]    idx_r;
  logic [MASK_W-1:0]   tabela_r [ROWS];
  logic                entrada_ready_r;
  logic                prog_ready_r;
  logic                ocupado_r;

  logic                s1_valid_r;
  logic [MASK_W-1:0]   s1_mask_r;
  logic [MASK_W-1:0]   s1_onehot_r;
  logic                saida_r;
  logic                saida_valid_r;

  logic [N_SEL-1:0]    linha_s;
  logic [N_DEC-1:0]    bit_s;
  logic                aceita_entrada_s;
  logic                aceita_prog_s;

  // Reset contents of one row; the default table only exists for the 3/4 geometry.
  function automatic logic [MASK_W-1:0] linha_padrao(input logic [N_SEL-1:0] linha);
    logic [MASK_W-1:0] r;
    r = {MASK_W{1'b0}};
    if (PADRAO_EN && (N_SEL == 3) && (N_DEC == 4)) begin
      case (32'(linha))
        32'd0, 32'd2, 32'd5: r = {MASK_W{1'b1}};
        32'd1:               r = {{(MASK_W-2){1'b0}}, 2'b11};
        default:             r = {MASK_W{1'b0}};
      endcase
    end else begin
      r = {MASK_W{1'b0}};
    end
    return r;
  endfunction

  function automatic logic [MASK_W-1:0] decodifica(input logic [N_DEC-1:0] sel);
    return {{(MASK_W-1){1'b0}}, 1'b1} << sel;
  endfunction

  // Field split and handshake acceptance.
  always_comb begin
    linha_s          = bus.entrada[N_SEL+N_DEC-1:N_DEC];
    bit_s            = bus.entrada[N_DEC-1:0];
    aceita_entrada_s = bus.entrada_valid && entrada_ready_r;
    aceita_prog_s    = bus.prog_valid && prog_ready_r;
  end

  // Control FSM, table writes and the row-by-row clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_r        <= OCIOSO;
      idx_r           <= {N_SEL{1'b0}};
      entrada_ready_r <= 1'b1;
      prog_ready_r    <= 1'b1;
      ocupado_r       <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        tabela_r[i] <= linha_padrao(N_SEL'(i));
      end
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (aceita_prog_s) begin
            tabela_r[bus.prog_ender] <= bus.prog_mascara;
          end
          // The write above still lands; the clear wipes it later.
          if (bus.limpar) begin
            estado_r        <= LIMPANDO;
            idx_r           <= {N_SEL{1'b0}};
            entrada_ready_r <= 1'b0;
            prog_ready_r    <= 1'b0;
            ocupado_r       <= 1'b1;
          end
        end
        LIMPANDO: begin
          tabela_r[idx_r] <= {MASK_W{1'b0}};
          if (idx_r == N_SEL'(ROWS - 1)) begin
            estado_r        <= OCIOSO;
            idx_r           <= {N_SEL{1'b0}};
            entrada_ready_r <= 1'b1;
            prog_ready_r    <= 1'b1;
            ocupado_r       <= 1'b0;
          end else begin
            idx_r <= idx_r + N_SEL'(1);
          end
        end
        default: begin
          estado_r        <= OCIOSO;
          idx_r           <= {N_SEL{1'b0}};
          entrada_ready_r <= 1'b1;
          prog_ready_r    <= 1'b1;
          ocupado_r       <= 1'b0;
        end
      endcase
    end
  end

  // Evaluation pipeline: stage 1 snapshots the mask (read-before-write), stage 2 reduces.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_r    <= 1'b0;
      s1_mask_r     <= {MASK_W{1'b0}};
      s1_onehot_r   <= {MASK_W{1'b0}};
      saida_r       <= 1'b0;
      saida_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= aceita_entrada_s;
      if (aceita_entrada_s) begin
        s1_mask_r   <= tabela_r[linha_s];
        s1_onehot_r <= decodifica(bit_s);
      end
      saida_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        saida_r <= |(s1_mask_r & s1_onehot_r);
      end
    end
  end

  assign bus.entrada_ready = entrada_ready_r;
  assign bus.prog_ready    = prog_ready_r;
  assign bus.ocupado       = ocupado_r;
  assign bus.saida         = saida_r;
  assign bus.saida_valid   = saida_valid_r;

endmodule
